pipe_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 24 ++
 rtl/pipe_ctrl_hazard.sv | 23 ++
 rtl/pipe_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding, stage indices and helpers
// for the pipeline controller.
package pipe_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      BOOT  = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      HALT  = 3'd4
   } state_t;

   localparam int IF_S  = 0;
   localparam int ID_S  = 1;
   localparam int EXE_S = 2;

   function automatic logic [15:0] sat_inc16(
      input logic [15:0] v,
      input logic        en
   );
      return (en && v != 16'hFFFF) ? v + 16'd1 : v;
   endfunction

endpackage

// File: rtl/pipe_ctrl_hazard.sv
// hazard_detect: combinational load-use detection between the
// instruction in EXE and the one in ID.
module hazard_detect #(
   parameter int REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] i_id_rs_addr,
   input  logic [REG_ADDR_W-1:0] i_id_rt_addr,
   input  logic [REG_ADDR_W-1:0] i_exe_write_addr,
   input  logic                  i_exe_reg_write,
   input  logic                  i_exe_mem_to_reg,
   output logic                  o_load_use
);

   logic w_match;

   assign w_match = (i_exe_write_addr == i_id_rs_addr) ||
                    (i_exe_write_addr == i_id_rt_addr);

   // r0 is hard-wired zero, so a load into it never hazards
   assign o_load_use = i_exe_reg_write && i_exe_mem_to_reg &&
                       (i_exe_write_addr != '0) && w_match;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: boot/run/drain/halt sequencer with per-stage enables and
// flushes. Define PIPE_CTRL_PERF_EN to add saturating perf counters.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int NUM_STAGES = 5,
   parameter int BR_STAGE   = 3,
   parameter int REG_ADDR_W = 5,
   parameter int BOOT_CNT_W = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_boot_up,
   input  logic                  i_boot_web,
   input  logic [REG_ADDR_W-1:0] i_id_rs_addr,
   input  logic [REG_ADDR_W-1:0] i_id_rt_addr,
   input  logic [REG_ADDR_W-1:0] i_exe_write_addr,
   input  logic                  i_exe_reg_write,
   input  logic                  i_exe_mem_to_reg,
   input  logic                  i_branch_taken,
   input  logic                  i_peri_web,
   input  logic                  i_peri_ready,
   input  logic                  i_halt_req,
   output logic                  o_pc_run,
   output logic                  o_pc_load,
   output logic [NUM_STAGES-1:0] o_stage_en,
   output logic [NUM_STAGES-1:0] o_stage_flush,
   output logic [BOOT_CNT_W-1:0] o_boot_cnt,
   output logic [2:0]            o_ctrl_state
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [15:0]           o_stall_cnt,
   output logic [15:0]           o_flush_cnt,
   output logic [15:0]           o_periwait_cnt
`endif
);

   localparam int DCW = $clog2(NUM_STAGES);
   localparam logic [NUM_STAGES-1:0] ALL = '1;
   localparam logic [NUM_STAGES-1:0] BR_MASK =
      NUM_STAGES'((1 << BR_STAGE) - 1);

   state_t                r_state, w_state_nxt;
   logic [BOOT_CNT_W-1:0] r_boot_cnt, w_boot_cnt_nxt;
   logic [DCW-1:0]        r_drain, w_drain_nxt;
   logic                  w_load_use;
   logic                  w_peri_stall;
   logic                  w_reboot;

   hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
      .i_id_rs_addr     (i_id_rs_addr),
      .i_id_rt_addr     (i_id_rt_addr),
      .i_exe_write_addr (i_exe_write_addr),
      .i_exe_reg_write  (i_exe_reg_write),
      .i_exe_mem_to_reg (i_exe_mem_to_reg),
      .o_load_use       (w_load_use)
   );

   assign w_peri_stall = !i_peri_web && !i_peri_ready;
   assign w_reboot     = i_boot_up &&
                         (r_state == RUN || r_state == DRAIN ||
                          r_state == HALT);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= IDLE;
         r_boot_cnt <= '0;
         r_drain    <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_boot_cnt <= w_boot_cnt_nxt;
         r_drain    <= w_drain_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_boot_cnt_nxt = r_boot_cnt;
      w_drain_nxt    = r_drain;
      unique case (r_state)
         IDLE: begin
            if (i_boot_up) begin
               w_state_nxt    = BOOT;
               w_boot_cnt_nxt = '0;
            end
         end
         BOOT: begin
            if (!i_boot_web && r_boot_cnt != '1)
               w_boot_cnt_nxt = r_boot_cnt + BOOT_CNT_W'(1);
            if (!i_boot_up)
               w_state_nxt = (w_boot_cnt_nxt != '0) ? RUN : IDLE;
         end
         RUN: begin
            if (i_boot_up) begin
               w_state_nxt    = BOOT;
               w_boot_cnt_nxt = '0;
            end else if (i_halt_req) begin
               w_state_nxt = DRAIN;
               w_drain_nxt = DCW'(NUM_STAGES - 1);
            end
         end
         DRAIN: begin
            if (i_boot_up) begin
               w_state_nxt    = BOOT;
               w_boot_cnt_nxt = '0;
            end else if (!w_peri_stall) begin
               w_drain_nxt = r_drain - DCW'(1);
               if (r_drain == DCW'(1))
                  w_state_nxt = HALT;
            end
         end
         HALT: begin
            if (i_boot_up) begin
               w_state_nxt    = BOOT;
               w_boot_cnt_nxt = '0;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_pc_run      = 1'b0;
      o_pc_load     = 1'b0;
      o_stage_en    = '0;
      o_stage_flush = ALL;
      if (!w_reboot) begin
         unique case (r_state)
            RUN: begin
               o_stage_flush = '0;
               if (w_peri_stall) begin
                  o_stage_en = '0;
               end else if (i_branch_taken) begin
                  o_pc_run      = 1'b1;
                  o_pc_load     = 1'b1;
                  o_stage_en    = ALL;
                  o_stage_flush = BR_MASK;
               end else if (w_load_use) begin
                  o_stage_en              = ALL;
                  o_stage_en[IF_S]        = 1'b0;
                  o_stage_en[ID_S]        = 1'b0;
                  o_stage_flush[EXE_S]    = 1'b1;
               end else begin
                  o_pc_run   = 1'b1;
                  o_stage_en = ALL;
               end
            end
            DRAIN: begin
               o_stage_flush = '0;
               if (!w_peri_stall) begin
                  o_stage_en          = ALL;
                  o_stage_flush[IF_S] = 1'b1;
               end
            end
            HALT: o_stage_flush = '0;
            default: ;
         endcase
      end
   end

   assign o_boot_cnt   = r_boot_cnt;
   assign o_ctrl_state = r_state;

`ifdef PIPE_CTRL_PERF_EN
   logic w_in_run;
   logic w_boot_entry;
   logic r_unused_guard;

   assign w_in_run     = (r_state == RUN) && !w_reboot;
   assign w_boot_entry = (w_state_nxt == BOOT) && (r_state != BOOT);

   always_ff @(posedge i_clk) begin
      if (i_rst || w_boot_entry) begin
         o_stall_cnt    <= '0;
         o_flush_cnt    <= '0;
         o_periwait_cnt <= '0;
      end else begin
         o_stall_cnt    <= sat_inc16(o_stall_cnt, w_in_run &&
                           !w_peri_stall && !i_branch_taken && w_load_use);
         o_flush_cnt    <= sat_inc16(o_flush_cnt, w_in_run &&
                           !w_peri_stall && i_branch_taken);
         o_periwait_cnt <= sat_inc16(o_periwait_cnt, w_peri_stall &&
                           (w_in_run || (r_state == DRAIN && !w_reboot)));
      end
   end

   assign r_unused_guard = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed test-plan steps followed by a random phase,
// all compared against a behavioural controller model.
module tb_pipe_ctrl;

   localparam int NS = 5;
   localparam int BR = 3;
   localparam int AW = 5;
   localparam int CW = 8;

   localparam int MI = 0;
   localparam int MB = 1;
   localparam int MR = 2;
   localparam int MD = 3;
   localparam int MH = 4;

   logic          clk = 1'b0;
   logic          rst, boot_up, boot_web;
   logic [AW-1:0] rs, rt, wa;
   logic          rw, m2r, br, peri_web, peri_ready, halt_req;
   logic          pc_run, pc_load;
   logic [NS-1:0] stage_en, stage_flush;
   logic [CW-1:0] boot_cnt;
   logic [2:0]    ctrl_state;

   int checks   = 0;
   int failures = 0;
   int m_mode   = MI;
   int m_words  = 0;
   int m_drain  = 0;

   always #5 clk = ~clk;

   pipe_ctrl #(
      .NUM_STAGES(NS), .BR_STAGE(BR),
      .REG_ADDR_W(AW), .BOOT_CNT_W(CW)
   ) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_boot_up        (boot_up),
      .i_boot_web       (boot_web),
      .i_id_rs_addr     (rs),
      .i_id_rt_addr     (rt),
      .i_exe_write_addr (wa),
      .i_exe_reg_write  (rw),
      .i_exe_mem_to_reg (m2r),
      .i_branch_taken   (br),
      .i_peri_web       (peri_web),
      .i_peri_ready     (peri_ready),
      .i_halt_req       (halt_req),
      .o_pc_run         (pc_run),
      .o_pc_load        (pc_load),
      .o_stage_en       (stage_en),
      .o_stage_flush    (stage_flush),
      .o_boot_cnt       (boot_cnt),
      .o_ctrl_state     (ctrl_state)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input bit do_chk);
      logic [NS-1:0] e_en, e_fl;
      logic          e_run, e_load;
      bit            lu, ps;
      #1;
      ps = !peri_web && !peri_ready;
      lu = rw && m2r && wa != 0 && (wa == rs || wa == rt);
      e_en = '0;
      e_fl = '1;
      e_run = 1'b0;
      e_load = 1'b0;
      if (!(boot_up && m_mode >= MR)) begin
         case (m_mode)
            MR: begin
               e_run  = !ps && (br || !lu);
               e_load = !ps && br;
               for (int s = 0; s < NS; s++) begin
                  e_en[s] = !(ps || (lu && !br && s < 2));
                  e_fl[s] = !ps && ((br && s < BR) ||
                                    (lu && !br && s == 2));
               end
            end
            MD: begin
               for (int s = 0; s < NS; s++) begin
                  e_en[s] = !ps;
                  e_fl[s] = !ps && s == 0;
               end
            end
            MH: e_fl = '0;
            default: ;
         endcase
      end
      if (do_chk) begin
         chk("pc_run", 32'(pc_run), 32'(e_run));
         chk("pc_load", 32'(pc_load), 32'(e_load));
         chk("stage_en", 32'(stage_en), 32'(e_en));
         chk("stage_flush", 32'(stage_flush), 32'(e_fl));
         chk("boot_cnt", 32'(boot_cnt), 32'(m_words));
         chk("ctrl_state", 32'(ctrl_state), 32'(m_mode));
      end
      @(posedge clk);
      if (rst) begin
         m_mode  = MI;
         m_words = 0;
      end else begin
         case (m_mode)
            MI: if (boot_up) begin
               m_mode = MB;
               m_words = 0;
            end
            MB: begin
               if (!boot_web && m_words < 255) m_words++;
               if (!boot_up) m_mode = (m_words != 0) ? MR : MI;
            end
            default: begin
               if (boot_up) begin
                  m_mode = MB;
                  m_words = 0;
               end else if (m_mode == MR && halt_req) begin
                  m_mode = MD;
                  m_drain = NS - 1;
               end else if (m_mode == MD && !ps) begin
                  m_drain--;
                  if (m_drain == 0) m_mode = MH;
               end
            end
         endcase
      end
      #1;
   endtask

   task automatic quiet();
      boot_up = 0; boot_web = 1; rs = 0; rt = 0; wa = 0;
      rw = 0; m2r = 0; br = 0; peri_web = 1; peri_ready = 1;
      halt_req = 0;
   endtask

   initial begin
      rst = 1;
      quiet();
      step(0);
      step(0);
      rst = 0;
      #1;
      chk("rst_state", 32'(ctrl_state), 32'(0));
      chk("rst_flush", 32'(stage_flush), 32'h1F);
      chk("rst_en", 32'(stage_en), 32'h0);
      step(1);

      // boot with four words
      boot_up = 1;
      step(1);
      for (int i = 0; i < 4; i++) begin
         boot_web = 0; step(1);
         boot_web = 1; step(1);
      end
      boot_up = 0;
      step(1);
      chk("boot_words", 32'(boot_cnt), 32'(4));
      chk("boot_run", 32'(pc_run), 32'(1));
      chk("boot_en", 32'(stage_en), 32'h1F);
      step(1);

      // empty boot
      rst = 1; step(0); rst = 0;
      boot_up = 1;
      for (int i = 0; i < 3; i++) step(1);
      boot_up = 0;
      step(1);
      chk("empty_idle", 32'(ctrl_state), 32'(0));
      chk("empty_run", 32'(pc_run), 32'(0));
      boot_up = 1; boot_web = 0; step(1); step(1); step(1);
      boot_up = 0; boot_web = 1; step(1);

      // load-use
      rw = 1; m2r = 1; wa = 8; rt = 8; rs = 3;
      #1;
      chk("lu_en", 32'(stage_en), 32'h1C);
      chk("lu_flush", 32'(stage_flush), 32'h04);
      chk("lu_run", 32'(pc_run), 32'(0));
      step(1);
      wa = 0; rt = 0;
      #1;
      chk("lu_r0_run", 32'(pc_run), 32'(1));
      chk("lu_r0_en", 32'(stage_en), 32'h1F);
      step(1);

      // branch beats load-use
      wa = 8; rt = 8; br = 1;
      #1;
      chk("br_load", 32'(pc_load), 32'(1));
      chk("br_flush", 32'(stage_flush), 32'h07);
      chk("br_en", 32'(stage_en), 32'h1F);
      step(1);
      quiet();

      // peripheral stall
      peri_web = 0; peri_ready = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("ps_en", 32'(stage_en), 32'h0);
         chk("ps_run", 32'(pc_run), 32'(0));
         chk("ps_flush", 32'(stage_flush), 32'h0);
         step(1);
      end
      quiet();
      #1;
      chk("ps_release", 32'(pc_run), 32'(1));
      step(1);

      // halt, drain, reboot
      halt_req = 1; step(1); halt_req = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("drain_state", 32'(ctrl_state), 32'(3));
         step(1);
      end
      #1;
      chk("halt_state", 32'(ctrl_state), 32'(4));
      chk("halt_en", 32'(stage_en), 32'h0);
      boot_up = 1;
      #1;
      chk("reboot_flush", 32'(stage_flush), 32'h1F);
      chk("reboot_run", 32'(pc_run), 32'(0));
      step(1);
      chk("reboot_state", 32'(ctrl_state), 32'(1));
      chk("reboot_cnt", 32'(boot_cnt), 32'(0));
      boot_up = 0; step(1);

      // random phase
      for (int n = 0; n < 1500; n++) begin
         rst        = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 99) < 8) boot_up = ~boot_up;
         boot_web   = $urandom_range(0, 1) == 1;
         rs         = AW'($urandom_range(0, 3));
         rt         = AW'($urandom_range(0, 3));
         wa         = AW'($urandom_range(0, 3));
         rw         = $urandom_range(0, 3) != 0;
         m2r        = $urandom_range(0, 1) == 1;
         br         = $urandom_range(0, 4) == 0;
         peri_web   = $urandom_range(0, 2) != 0;
         peri_ready = $urandom_range(0, 1) == 1;
         halt_req   = $urandom_range(0, 29) == 0;
         step(1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
